// File: rtl/sum_window_accum.sv
// sum_window_accum: sums a programmable window of adder results and hands the total
// to a valid/ready sink. Define SUM_ACC_SAT_EN to saturate on overflow instead of wrapping.
module sum_window_accum #(
  parameter int IN_W  = 9,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic             ovf_r, ovf_s;
  logic             out_valid_r, out_valid_s;
  logic [ACC_W-1:0] acc_out_r, acc_out_s;
  logic             ovf_out_r, ovf_out_s;

  logic             in_ready_s;
  logic             beat_s;
  logic             take_s;
  logic             last_s;
  logic             first_one_s;
  logic [CNT_W-1:0] first_len_s;
  logic [ACC_W-1:0] beat_ext_s;
  logic [ACC_W:0]   step_s;

  // Returns {carry, new_acc}; with saturation the sum pins at all-ones once it carries.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] addend);
    logic [ACC_W:0] raw;
    raw = {1'b0, acc} + {1'b0, addend};
`ifdef SUM_ACC_SAT_EN
    if (raw[ACC_W]) begin
      acc_step = {1'b1, {ACC_W{1'b1}}};
    end else begin
      acc_step = raw;
    end
`else
    acc_step = raw;
`endif
  endfunction

  assign beat_s      = in_valid && in_ready_s;
  assign take_s      = out_valid_r && out_ready;
  assign first_len_s = (win_len == {CNT_W{1'b0}}) ? CNT_W'(1) : win_len;
  assign first_one_s = (first_len_s == CNT_W'(1));
  assign beat_ext_s  = ACC_W'(sum_in);
  assign step_s      = acc_step(acc_r, beat_ext_s);
  assign last_s      = (({1'b0, cnt_r} + (CNT_W+1)'(1)) == {1'b0, len_r});

  // Next-state and datapath update; a beat in IDLE or HOLD always opens a new window.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    ovf_s       = ovf_r;
    out_valid_s = out_valid_r;
    acc_out_s   = acc_out_r;
    ovf_out_s   = ovf_out_r;
    if (clear) begin
      state_s     = ST_IDLE;
      cnt_s       = {CNT_W{1'b0}};
      acc_s       = {ACC_W{1'b0}};
      ovf_s       = 1'b0;
      out_valid_s = 1'b0;
      acc_out_s   = {ACC_W{1'b0}};
      ovf_out_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (beat_s) begin
            len_s       = first_len_s;
            cnt_s       = CNT_W'(1);
            acc_s       = beat_ext_s;
            ovf_s       = 1'b0;
            out_valid_s = first_one_s;
            if (first_one_s) begin
              state_s   = ST_HOLD;
              acc_out_s = beat_ext_s;
              ovf_out_s = 1'b0;
            end else begin
              state_s   = ST_ACCUM;
            end
          end else if (take_s) begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
          end else begin
            state_s     = state_r;
          end
        end
        ST_ACCUM: begin
          if (beat_s) begin
            acc_s = step_s[ACC_W-1:0];
            ovf_s = ovf_r | step_s[ACC_W];
            cnt_s = cnt_r + CNT_W'(1);
            if (last_s) begin
              state_s     = ST_HOLD;
              out_valid_s = 1'b1;
              acc_out_s   = step_s[ACC_W-1:0];
              ovf_out_s   = ovf_r | step_s[ACC_W];
            end else begin
              state_s     = ST_ACCUM;
            end
          end else begin
            state_s = ST_ACCUM;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          cnt_s       = {CNT_W{1'b0}};
          acc_s       = {ACC_W{1'b0}};
          ovf_s       = 1'b0;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Window and result registers; reset drops any partial window and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r       <= CNT_W'(1);
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      acc_out_r   <= {ACC_W{1'b0}};
      ovf_out_r   <= 1'b0;
    end else begin
      len_r       <= len_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      ovf_r       <= ovf_s;
      out_valid_r <= out_valid_s;
      acc_out_r   <= acc_out_s;
      ovf_out_r   <= ovf_out_s;
    end
  end

  // Output decode; a result taken this cycle frees the block for a new beat.
  always_comb begin
    in_ready_s = !out_valid_r || out_ready;
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign acc_out   = acc_out_r;
  assign ovf_out   = ovf_out_r;

endmodule
